// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle bit positions and control payload types for the pipeline register banks.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_RA_W   = 5;

    localparam int unsigned CTL_W  = 10;
    localparam int unsigned MCTL_W = 6;

    // id_ctrl / ex_ctrl bit positions
    localparam int unsigned CTL_REGDST   = 9;
    localparam int unsigned CTL_JUMP     = 8;
    localparam int unsigned CTL_BRANCH   = 7;
    localparam int unsigned CTL_MEMREAD  = 6;
    localparam int unsigned CTL_MEMTOREG = 5;
    localparam int unsigned CTL_MEMWRITE = 4;
    localparam int unsigned CTL_ALUSRC   = 3;
    localparam int unsigned CTL_ALUOP_HI = 2;
    localparam int unsigned CTL_ALUOP_LO = 1;
    localparam int unsigned CTL_REGWRITE = 0;

    // ex_mctrl / mem_ctrl bit positions
    localparam int unsigned M_JUMP     = 5;
    localparam int unsigned M_BRANCH   = 4;
    localparam int unsigned M_MEMREAD  = 3;
    localparam int unsigned M_MEMTOREG = 2;
    localparam int unsigned M_MEMWRITE = 1;
    localparam int unsigned M_REGWRITE = 0;

    typedef struct packed {
        logic       regdst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic jump;
        logic branch;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic reg_write;
    } mctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// Width-parameterised register: async active-low clear, then synchronous clear, then load enable.
module pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_stage_regs.sv
// IF/ID, ID/EX and EX/MEM register banks of the 5-stage datapath; each bank is a single pipe_reg.
module pipeline_stage_regs
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned RA_W   = PIPE_RA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ifid_en,
    input  logic              ifid_flush,
    input  logic [DATA_W-1:0] if_pc_plus1,
    input  logic [DATA_W-1:0] if_instr,
    output logic [DATA_W-1:0] id_pc_plus1,
    output logic [DATA_W-1:0] id_instr,

    input  logic              idex_flush,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_sext,
    input  logic [RA_W-1:0]   id_rt_addr,
    input  logic [RA_W-1:0]   id_rd_addr,
    input  logic [CTL_W-1:0]  id_ctrl,
    output logic [DATA_W-1:0] ex_pc_plus1,
    output logic [DATA_W-1:0] ex_instr,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_sext,
    output logic [RA_W-1:0]   ex_rt_addr,
    output logic [RA_W-1:0]   ex_rd_addr,
    output logic [CTL_W-1:0]  ex_ctrl,

    input  logic [DATA_W-1:0] ex_branch_addr,
    input  logic [DATA_W-1:0] ex_alu_res,
    input  logic [DATA_W-1:0] ex_rt_fwd,
    input  logic              ex_zero,
    input  logic [RA_W-1:0]   ex_dest_addr,
    input  logic [MCTL_W-1:0] ex_mctrl,
    output logic [DATA_W-1:0] mem_branch_addr,
    output logic [DATA_W-1:0] mem_alu_res,
    output logic [DATA_W-1:0] mem_rt,
    output logic              mem_zero,
    output logic [RA_W-1:0]   mem_dest_addr,
    output logic [MCTL_W-1:0] mem_ctrl
);

    localparam int unsigned IFID_W  = 2 * DATA_W;
    localparam int unsigned IDEX_W  = 5 * DATA_W + 2 * RA_W + CTL_W;
    localparam int unsigned EXMEM_W = 3 * DATA_W + 1 + RA_W + MCTL_W;

    logic [IFID_W-1:0]  ifid_q;
    logic [IDEX_W-1:0]  idex_q;
    logic [EXMEM_W-1:0] exmem_q;

    // IF/ID: flush (branch squash) beats hold
    pipe_reg #(.W(IFID_W)) u_ifid (
        .clk   (clk),
        .rst_n (reset),
        .clr   (ifid_flush),
        .en    (ifid_en),
        .d     ({if_pc_plus1, if_instr}),
        .q     (ifid_q)
    );
    assign {id_pc_plus1, id_instr} = ifid_q;

    // ID/EX: loads every edge; flush inserts an all-zero bubble
    pipe_reg #(.W(IDEX_W)) u_idex (
        .clk   (clk),
        .rst_n (reset),
        .clr   (idex_flush),
        .en    (1'b1),
        .d     ({id_pc_plus1, id_instr, id_rs_data, id_rt_data, id_sext,
                 id_rt_addr, id_rd_addr, id_ctrl}),
        .q     (idex_q)
    );
    assign {ex_pc_plus1, ex_instr, ex_rs_data, ex_rt_data, ex_sext,
            ex_rt_addr, ex_rd_addr, ex_ctrl} = idex_q;

    // EX/MEM: free-running capture
    pipe_reg #(.W(EXMEM_W)) u_exmem (
        .clk   (clk),
        .rst_n (reset),
        .clr   (1'b0),
        .en    (1'b1),
        .d     ({ex_branch_addr, ex_alu_res, ex_rt_fwd, ex_zero,
                 ex_dest_addr, ex_mctrl}),
        .q     (exmem_q)
    );
    assign {mem_branch_addr, mem_alu_res, mem_rt, mem_zero,
            mem_dest_addr, mem_ctrl} = exmem_q;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Directed bench for pipeline_stage_regs: reset, flow, hold, bubble, flush priority, async reset.
module tb_pipeline_stage_regs;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RA_W   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              ifid_en, ifid_flush, idex_flush;
    logic [DATA_W-1:0] if_pc_plus1, if_instr;
    logic [DATA_W-1:0] id_pc_plus1, id_instr;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_sext;
    logic [RA_W-1:0]   id_rt_addr, id_rd_addr;
    logic [9:0]        id_ctrl;
    logic [DATA_W-1:0] ex_pc_plus1, ex_instr, ex_rs_data, ex_rt_data, ex_sext;
    logic [RA_W-1:0]   ex_rt_addr, ex_rd_addr;
    logic [9:0]        ex_ctrl;
    logic [DATA_W-1:0] ex_branch_addr, ex_alu_res, ex_rt_fwd;
    logic              ex_zero;
    logic [RA_W-1:0]   ex_dest_addr;
    logic [5:0]        ex_mctrl;
    logic [DATA_W-1:0] mem_branch_addr, mem_alu_res, mem_rt;
    logic              mem_zero;
    logic [RA_W-1:0]   mem_dest_addr;
    logic [5:0]        mem_ctrl;

    int checks = 0;
    int errors = 0;

    pipeline_stage_regs #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .if_pc_plus1     (if_pc_plus1),
        .if_instr        (if_instr),
        .id_pc_plus1     (id_pc_plus1),
        .id_instr        (id_instr),
        .idex_flush      (idex_flush),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_sext         (id_sext),
        .id_rt_addr      (id_rt_addr),
        .id_rd_addr      (id_rd_addr),
        .id_ctrl         (id_ctrl),
        .ex_pc_plus1     (ex_pc_plus1),
        .ex_instr        (ex_instr),
        .ex_rs_data      (ex_rs_data),
        .ex_rt_data      (ex_rt_data),
        .ex_sext         (ex_sext),
        .ex_rt_addr      (ex_rt_addr),
        .ex_rd_addr      (ex_rd_addr),
        .ex_ctrl         (ex_ctrl),
        .ex_branch_addr  (ex_branch_addr),
        .ex_alu_res      (ex_alu_res),
        .ex_rt_fwd       (ex_rt_fwd),
        .ex_zero         (ex_zero),
        .ex_dest_addr    (ex_dest_addr),
        .ex_mctrl        (ex_mctrl),
        .mem_branch_addr (mem_branch_addr),
        .mem_alu_res     (mem_alu_res),
        .mem_rt          (mem_rt),
        .mem_zero        (mem_zero),
        .mem_dest_addr   (mem_dest_addr),
        .mem_ctrl        (mem_ctrl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".id_pc"},    64'(id_pc_plus1),     64'd0);
        check({tag, ".id_instr"}, 64'(id_instr),        64'd0);
        check({tag, ".ex_pc"},    64'(ex_pc_plus1),     64'd0);
        check({tag, ".ex_instr"}, 64'(ex_instr),        64'd0);
        check({tag, ".ex_rs"},    64'(ex_rs_data),      64'd0);
        check({tag, ".ex_rt"},    64'(ex_rt_data),      64'd0);
        check({tag, ".ex_sext"},  64'(ex_sext),         64'd0);
        check({tag, ".ex_rta"},   64'(ex_rt_addr),      64'd0);
        check({tag, ".ex_rda"},   64'(ex_rd_addr),      64'd0);
        check({tag, ".ex_ctrl"},  64'(ex_ctrl),         64'd0);
        check({tag, ".mem_br"},   64'(mem_branch_addr), 64'd0);
        check({tag, ".mem_alu"},  64'(mem_alu_res),     64'd0);
        check({tag, ".mem_rt"},   64'(mem_rt),          64'd0);
        check({tag, ".mem_zero"}, 64'(mem_zero),        64'd0);
        check({tag, ".mem_dest"}, 64'(mem_dest_addr),   64'd0);
        check({tag, ".mem_ctrl"}, 64'(mem_ctrl),        64'd0);
    endtask

    task automatic drive_all_ones();
        if_pc_plus1 = '1; if_instr = '1;
        id_rs_data = '1; id_rt_data = '1; id_sext = '1;
        id_rt_addr = '1; id_rd_addr = '1; id_ctrl = '1;
        ex_branch_addr = '1; ex_alu_res = '1; ex_rt_fwd = '1;
        ex_zero = 1'b1; ex_dest_addr = '1; ex_mctrl = '1;
    endtask

    initial begin
        reset = 1'b1;
        ifid_en = 1'b1; ifid_flush = 1'b0; idex_flush = 1'b0;
        drive_all_ones();

        // Async reset before any clock edge
        #2 reset = 1'b0;
        #1 check_all_zero("rst_async");
        reset = 1'b1;
        tick();
        check("rst_rel.id_instr", 64'(id_instr),    64'hFFFF_FFFF);
        check("rst_rel.id_pc",    64'(id_pc_plus1), 64'hFFFF_FFFF);
        check("rst_rel.ex_instr", 64'(ex_instr),    64'd0);
        check("rst_rel.ex_rs",    64'(ex_rs_data),  64'hFFFF_FFFF);
        check("rst_rel.ex_rda",   64'(ex_rd_addr),  64'h1F);
        check("rst_rel.ex_ctrl",  64'(ex_ctrl),     64'h3FF);
        check("rst_rel.mem_alu",  64'(mem_alu_res), 64'hFFFF_FFFF);
        check("rst_rel.mem_zero", 64'(mem_zero),    64'd1);
        check("rst_rel.mem_ctrl", 64'(mem_ctrl),    64'h3F);

        // Pipeline flow
        if_instr = 32'h2002_0005; if_pc_plus1 = 32'd1;
        id_ctrl = 10'b1000000101; id_rs_data = 32'd7;
        id_rt_data = '0; id_sext = '0; id_rt_addr = '0; id_rd_addr = '0;
        ex_alu_res = 32'h0000_000C; ex_dest_addr = 5'd3;
        ex_branch_addr = '0; ex_rt_fwd = '0; ex_zero = 1'b0; ex_mctrl = 6'b100001;
        #1;
        check("flow.no_comb", 64'(id_instr), 64'hFFFF_FFFF);
        tick();
        check("flow.id_instr", 64'(id_instr),      64'h2002_0005);
        check("flow.id_pc",    64'(id_pc_plus1),   64'd1);
        check("flow.ex_ctrl",  64'(ex_ctrl),       64'h205);
        check("flow.ex_rs",    64'(ex_rs_data),    64'd7);
        check("flow.ex_instr", 64'(ex_instr),      64'hFFFF_FFFF);
        check("flow.mem_alu",  64'(mem_alu_res),   64'hC);
        check("flow.mem_dest", 64'(mem_dest_addr), 64'd3);
        check("flow.mem_ctrl", 64'(mem_ctrl),      64'h21);
        tick();
        check("flow2.ex_instr", 64'(ex_instr),    64'h2002_0005);
        check("flow2.ex_pc",    64'(ex_pc_plus1), 64'd1);

        // IF/ID hold
        if_instr = 32'hAAAA_AAAA;
        tick();
        check("hold.load", 64'(id_instr), 64'hAAAA_AAAA);
        ifid_en = 1'b0; if_instr = 32'h1111_1111;
        tick();
        check("hold.c1", 64'(id_instr), 64'hAAAA_AAAA);
        if_instr = 32'h2222_2222;
        tick();
        check("hold.c2", 64'(id_instr), 64'hAAAA_AAAA);
        check("hold.ex_instr", 64'(ex_instr), 64'hAAAA_AAAA);
        ifid_en = 1'b1;
        tick();
        check("hold.resume", 64'(id_instr), 64'h2222_2222);

        // Load-use bubble with IF/ID held
        ifid_en = 1'b0; idex_flush = 1'b1;
        id_ctrl = 10'b0011001011; id_rs_data = 32'd5; id_rt_data = 32'd6;
        id_sext = 32'd7; id_rt_addr = 5'd8; id_rd_addr = 5'd9;
        ex_alu_res = 32'h55;
        tick();
        check("bub.ex_ctrl",  64'(ex_ctrl),     64'd0);
        check("bub.ex_rs",    64'(ex_rs_data),  64'd0);
        check("bub.ex_rt",    64'(ex_rt_data),  64'd0);
        check("bub.ex_sext",  64'(ex_sext),     64'd0);
        check("bub.ex_rta",   64'(ex_rt_addr),  64'd0);
        check("bub.ex_rda",   64'(ex_rd_addr),  64'd0);
        check("bub.ex_instr", 64'(ex_instr),    64'd0);
        check("bub.ex_pc",    64'(ex_pc_plus1), 64'd0);
        check("bub.id_held",  64'(id_instr),    64'h2222_2222);
        check("bub.mem_alu",  64'(mem_alu_res), 64'h55);
        idex_flush = 1'b0;
        tick();
        check("bub2.ex_ctrl",  64'(ex_ctrl),    64'h0CB);
        check("bub2.ex_rs",    64'(ex_rs_data), 64'd5);
        check("bub2.ex_rda",   64'(ex_rd_addr), 64'd9);
        check("bub2.ex_instr", 64'(ex_instr),   64'h2222_2222);

        // IF/ID flush beats hold; ID/EX unaffected
        ifid_flush = 1'b1; ifid_en = 1'b0; id_rs_data = 32'd11;
        tick();
        check("flush.id_instr", 64'(id_instr),    64'd0);
        check("flush.id_pc",    64'(id_pc_plus1), 64'd0);
        check("flush.ex_ctrl",  64'(ex_ctrl),     64'h0CB);
        check("flush.ex_rs",    64'(ex_rs_data),  64'd11);
        ifid_flush = 1'b0; ifid_en = 1'b1; if_instr = 32'h1234_5678; if_pc_plus1 = 32'd40;
        tick();
        check("flush2.id_instr", 64'(id_instr), 64'h1234_5678);
        check("flush2.ex_instr", 64'(ex_instr), 64'd0);

        // Async reset mid-stream
        drive_all_ones();
        tick();
        check("pre_rst.id_instr", 64'(id_instr), 64'hFFFF_FFFF);
        #2 reset = 1'b0;
        #1 check_all_zero("rst_mid");
        tick();
        check_all_zero("rst_held");
        reset = 1'b1;
        #1 check_all_zero("rst_released");
        tick();
        check("rst_post.id_instr", 64'(id_instr),    64'hFFFF_FFFF);
        check("rst_post.ex_instr", 64'(ex_instr),    64'd0);
        check("rst_post.ex_ctrl",  64'(ex_ctrl),     64'h3FF);
        check("rst_post.mem_rt",   64'(mem_rt),      64'hFFFF_FFFF);
        check("rst_post.mem_br",   64'(mem_branch_addr), 64'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
